// File: rtl/pulse_counter_pkg.sv
// Shared register map, bit positions and mode encoding for the pulse counter block.
package pulse_counter_pkg;

  localparam logic [9:0] ADDR_CR_DEF  = 10'h0;
  localparam logic [9:0] ADDR_SR_DEF  = 10'h4;
  localparam logic [9:0] ADDR_CNT_DEF = 10'h8;
  localparam logic [9:0] ADDR_CMP_DEF = 10'hC;

  localparam int unsigned CR_EN     = 0;
  localparam int unsigned CR_CLR    = 1;
  localparam int unsigned CR_MODE   = 2;
  localparam int unsigned CR_OVF_IE = 3;
  localparam int unsigned CR_CMP_IE = 4;

  localparam int unsigned SR_OVF = 0;
  localparam int unsigned SR_CMP = 1;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

endpackage

// File: rtl/pulse_edge_counter.sv
// Rising-edge detector feeding a wrap/saturate counter; flags overflow and compare
// match as single-cycle events aligned with the count update.
module pulse_edge_counter
  import pulse_counter_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic             en,
  input  mode_e            mode,
  input  logic             clr,
  input  logic [CNT_W-1:0] cmp,
  output logic [CNT_W-1:0] count,
  output logic             ovf_evt,
  output logic             cmp_evt
);

  logic             prev;
  logic             edge_det;
  logic             step;
  logic [CNT_W-1:0] nxt;

  // clr suppresses the step so a colliding edge raises no event
  always_comb begin
    edge_det = pulse_in & ~prev;
    step     = edge_det & en & ~clr;
    ovf_evt  = step & (count == '1);
    if (count == '1) begin
      nxt = (mode == MODE_SAT) ? '1 : '0;
    end else begin
      nxt = count + CNT_W'(1);
    end
    cmp_evt = step & (nxt == cmp);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev  <= 1'b0;
      count <= '0;
    end else begin
      prev <= pulse_in;
      if (clr) begin
        count <= '0;
      end else if (step) begin
        count <= nxt;
      end
    end
  end

endmodule

// File: rtl/pulse_counter_ctrl.sv
// Pulse counter with CR/SR/CNT/CMP register file, sticky W1C status and a
// registered maskable interrupt.
module pulse_counter_ctrl
  import pulse_counter_pkg::*;
#(
  parameter int unsigned            CNT_W    = 8,
  parameter int unsigned            ADDR_W   = 10,
  parameter logic [ADDR_W-1:0]      ADDR_CR  = ADDR_W'(ADDR_CR_DEF),
  parameter logic [ADDR_W-1:0]      ADDR_SR  = ADDR_W'(ADDR_SR_DEF),
  parameter logic [ADDR_W-1:0]      ADDR_CNT = ADDR_W'(ADDR_CNT_DEF),
  parameter logic [ADDR_W-1:0]      ADDR_CMP = ADDR_W'(ADDR_CMP_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              pulse_in,
  output logic [31:0]       rdata,
  output logic [CNT_W-1:0]  count,
  output logic              irq
);

  logic             cr_en;
  mode_e            cr_mode;
  logic             cr_ovf_ie;
  logic             cr_cmp_ie;
  logic             sr_ovf;
  logic             sr_cmp;
  logic [CNT_W-1:0] cmp_q;

  logic wr_cr;
  logic wr_sr;
  logic wr_cmp;
  logic clr;
  logic ovf_evt;
  logic cmp_evt;
  logic unused_wdata;

  always_comb begin
    wr_cr        = wr_en && (addr == ADDR_CR);
    wr_sr        = wr_en && (addr == ADDR_SR);
    wr_cmp       = wr_en && (addr == ADDR_CMP);
    clr          = wr_cr && wdata[CR_CLR];
    unused_wdata = ^wdata;
  end

  pulse_edge_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .pulse_in(pulse_in),
    .en      (cr_en),
    .mode    (cr_mode),
    .clr     (clr),
    .cmp     (cmp_q),
    .count   (count),
    .ovf_evt (ovf_evt),
    .cmp_evt (cmp_evt)
  );

  // event OR-ed after the clear term so a same-cycle set beats W1C
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cr_en     <= 1'b0;
      cr_mode   <= MODE_WRAP;
      cr_ovf_ie <= 1'b0;
      cr_cmp_ie <= 1'b0;
      sr_ovf    <= 1'b0;
      sr_cmp    <= 1'b0;
      cmp_q     <= '1;
      irq       <= 1'b0;
    end else begin
      if (wr_cr) begin
        cr_en     <= wdata[CR_EN];
        cr_mode   <= mode_e'(wdata[CR_MODE]);
        cr_ovf_ie <= wdata[CR_OVF_IE];
        cr_cmp_ie <= wdata[CR_CMP_IE];
      end
      if (wr_cmp) begin
        cmp_q <= wdata[CNT_W-1:0];
      end
      sr_ovf <= ovf_evt | (sr_ovf & ~(wr_sr & wdata[SR_OVF]));
      sr_cmp <= cmp_evt | (sr_cmp & ~(wr_sr & wdata[SR_CMP]));
      irq    <= (sr_ovf & cr_ovf_ie) | (sr_cmp & cr_cmp_ie);
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (addr)
        ADDR_CR: begin
          rdata[CR_EN]     = cr_en;
          rdata[CR_MODE]   = cr_mode;
          rdata[CR_OVF_IE] = cr_ovf_ie;
          rdata[CR_CMP_IE] = cr_cmp_ie;
        end
        ADDR_SR: begin
          rdata[SR_OVF] = sr_ovf;
          rdata[SR_CMP] = sr_cmp;
        end
        ADDR_CNT: rdata = 32'(count);
        ADDR_CMP: rdata = 32'(cmp_q);
        default:  rdata = '0;
      endcase
    end
  end

endmodule
